// File: rtl/nand_seq_ctrl.sv
// rtl/nand_seq_ctrl.sv - micro-programmed sequencer sharing one bitwise NAND unit
// Runs a loaded list of NAND steps over a scratch register file; r0=a, r1=b, r[NREG-1]=result.
module nand_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int NREG  = 8,
  parameter int NSTEP = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prog_we,
  input  logic [2:0]       prog_addr,
  input  logic [8:0]       prog_data,
  input  logic             prog_len_we,
  input  logic [3:0]       prog_len,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] L_NSTEP = 4'(NSTEP);
  localparam logic [2:0] L_RES   = 3'(NREG - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_regs [NREG];
  logic [8:0]       r_mem  [NSTEP];
  logic [3:0]       r_len;
  logic [2:0]       r_sc;
  logic [WIDTH-1:0] r_result;
  logic             r_err;

  logic [8:0]       w_word;
  logic [2:0]       w_dst;
  logic [2:0]       w_src_a;
  logic [2:0]       w_src_b;
  logic [WIDTH-1:0] w_nand;
  logic             w_last;

  assign w_word  = r_mem[r_sc];
  assign w_dst   = w_word[8:6];
  assign w_src_a = w_word[5:3];
  assign w_src_b = w_word[2:0];
  assign w_nand  = ~(r_regs[w_src_a] & r_regs[w_src_b]);
  assign w_last  = ({1'b0, r_sc} == (r_len - 4'd1));

  assign busy   = (r_state == S_LOAD) || (r_state == S_EXEC);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign err    = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_len    <= 4'd0;
      r_sc     <= 3'd0;
      r_result <= '0;
      r_err    <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      for (int i = 0; i < NSTEP; i++) r_mem[i] <= 9'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (prog_we) r_mem[prog_addr] <= prog_data;
          if (prog_len_we) begin
            if (prog_len > L_NSTEP) r_err <= 1'b1;
            else                    r_len <= prog_len;
          end
          if (start) begin
            r_regs[0] <= a;
            r_regs[1] <= b;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          for (int i = 2; i < NREG; i++) r_regs[i] <= '0;
          r_sc <= 3'd0;
          if (r_len == 4'd0) begin
            r_result <= '0;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_regs[w_dst] <= w_nand;
          r_sc          <= r_sc + 3'd1;
          // Capture the result together with the final write so it is valid while done is high.
          if (w_last) begin
            r_result <= (w_dst == L_RES) ? w_nand : r_regs[NREG-1];
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_seq_ctrl.sv
// tb/tb_nand_seq_ctrl.sv - directed and randomized checks of nand_seq_ctrl against a program model
module tb_nand_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       prog_we = 1'b0;
  logic [2:0] prog_addr = 3'd0;
  logic [8:0] prog_data = 9'd0;
  logic       prog_len_we = 1'b0;
  logic [3:0] prog_len = 4'd0;
  logic       start = 1'b0;
  logic [3:0] t_a = 4'd0;
  logic [3:0] t_b = 4'd0;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [8:0] m_mem [8];
  int         m_len;

  nand_seq_ctrl #(.WIDTH(4), .NREG(8), .NSTEP(8)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len_we(prog_len_we), .prog_len(prog_len),
    .start(start), .a(t_a), .b(t_b), .busy(busy), .done(done),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] step(input int dst, input int sa, input int sb);
    return {3'(dst), 3'(sa), 3'(sb)};
  endfunction

  // Straight evaluation of the stored program as a list of NAND assignments.
  function automatic logic [3:0] model_eval(input logic [3:0] ma, input logic [3:0] mb);
    logic [3:0] rr [8];
    logic [8:0] w;
    for (int i = 0; i < 8; i++) rr[i] = 4'd0;
    rr[0] = ma;
    rr[1] = mb;
    for (int s = 0; s < m_len; s++) begin
      w = m_mem[s];
      rr[w[8:6]] = ~(rr[w[5:3]] & rr[w[2:0]]);
    end
    return rr[7];
  endfunction

  task automatic wr_prog(input int addr, input logic [8:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 3'(addr); prog_data = data;
    @(posedge clk); #1;
    prog_we = 1'b0;
    m_mem[addr] = data;
  endtask

  task automatic wr_len(input logic [3:0] len);
    @(negedge clk);
    prog_len_we = 1'b1; prog_len = len;
    @(posedge clk); #1;
    prog_len_we = 1'b0;
    if (len <= 4'd8) m_len = int'(len);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_mem[i] = 9'd0;
    m_len = 0;
  endtask

  // Runs one evaluation; with disturb set, start and prog_we are held high from the 2nd busy cycle through done.
  task automatic do_run(input string tag, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] exp, input bit disturb);
    int n;
    n = m_len;
    @(negedge clk);
    start = 1'b1; t_a = ra; t_b = rb;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (disturb && k == 2) begin
        start = 1'b1; t_a = 4'hF; t_b = 4'h0;
        prog_we = 1'b1; prog_addr = 3'd0; prog_data = 9'h1FF;
      end
      chk({tag, "_busy"}, 32'(busy), 32'(k <= n + 1));
      chk({tag, "_done"}, 32'(done), 32'(k == n + 2));
      if (k == n + 2) chk({tag, "_result"}, 32'(result), 32'(exp));
    end
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    chk({tag, "_after_done"}, 32'(done), 32'd0);
    chk({tag, "_after_busy"}, 32'(busy), 32'd0);
    chk({tag, "_held"}, 32'(result), 32'(exp));
  endtask

  initial begin
    logic [3:0] ra, rb, exp;
    for (int i = 0; i < 8; i++) m_mem[i] = 9'd0;
    m_len = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // f8 = ~a & b via three NAND steps
    wr_prog(0, step(2, 0, 0));
    wr_prog(1, step(3, 2, 1));
    wr_prog(2, step(7, 3, 3));
    wr_len(4'd3);
    do_run("f8", 4'b0101, 4'b0011, 4'b0010, 1'b0);
    for (int v = 0; v < 16; v++) begin
      ra = 4'(v);
      rb = 4'(v * 7 + 3);
      do_run("f8_sweep", ra, rb, ~ra & rb, 1'b0);
    end

    // Disturbance while busy must not change the run or the program
    do_run("busy_ign", 4'b0101, 4'b0011, 4'b0010, 1'b1);
    do_run("rerun", 4'b0101, 4'b0011, 4'b0010, 1'b0);

    // Reset in the 2nd EXEC cycle
    @(negedge clk);
    start = 1'b1; t_a = 4'b0101; t_b = 4'b0011;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_mem[i] = 9'd0;
    m_len = 0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    do_run("after_abort", 4'hF, 4'hF, 4'h0, 1'b0);

    // len=0 gives a cleared result
    wr_prog(0, step(7, 0, 1));
    do_run("len0", 4'hF, 4'hF, 4'h0, 1'b0);

    // In-place steps
    wr_prog(1, step(7, 7, 7));
    wr_len(4'd2);
    do_run("inplace", 4'hC, 4'hA, 4'h8, 1'b0);

    // Over-range length is rejected and err is sticky
    wr_len(4'd9);
    @(negedge clk);
    chk("err_set", 32'(err), 32'd1);
    do_run("err_len_kept", 4'hC, 4'hA, 4'h8, 1'b0);
    chk("err_sticky", 32'(err), 32'd1);

    // Randomized programs, lengths 0..8, against the model
    for (int r = 0; r < 24; r++) begin
      for (int s = 0; s < 8; s++) wr_prog(s, 9'($urandom));
      wr_len(4'($urandom_range(0, 8)));
      ra = 4'($urandom);
      rb = 4'($urandom);
      exp = model_eval(ra, rb);
      do_run("rand", ra, rb, exp, 1'b0);
    end
    chk("err_still", 32'(err), 32'd1);

    do_reset();
    @(negedge clk);
    chk("err_cleared", 32'(err), 32'd0);
    chk("result_cleared", 32'(result), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
